// File: rtl/ad9958_spi_tx.sv
// AD9958 serial-port transmitter: shifts a right-aligned payload MSB-first in
// 1-bit or 4-bit mode, holding CS_N low between back-to-back requests.
module ad9958_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic        four_bit,
  input  logic [5:0]  bits_to_send,
  input  logic [63:0] data_input,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic [3:0]  sdio,
  output logic [1:0]  fsm_state
);

  // Handshake: a request is taken on any edge where trigger=1, bits_to_send!=0
  // and no transfer is running (IDLE or HOLD); busy rises on that same edge and
  // falls on the edge that ends the last SCLK high phase.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] HOLD_ONE  = CW'(1);

  logic [1:0]    state;
  logic [63:0]   shift_reg;
  logic [5:0]    units;
  logic          mode4;
  logic [HW-1:0] half_cnt;
  logic [CW-1:0] hold_cnt;

  logic          accept;
  logic [6:0]    shamt;
  logic [6:0]    len_plus3;
  logic [63:0]   load_sr;
  logic [5:0]    load_units;
  logic [63:0]   next_sr;

  function automatic logic [3:0] unit_of(input logic [63:0] v, input logic m);
    return m ? v[63:60] : {3'b000, v[63]};
  endfunction

  assign fsm_state  = state;
  assign accept     = ((state == IDLE) || (state == HOLD)) && trigger && (bits_to_send != 6'd0);
  assign shamt      = 7'd64 - {1'b0, bits_to_send};
  // MSB-align so the first payload bit sits at bit 63; zeros fill the padding.
  assign load_sr    = data_input << shamt;
  assign len_plus3  = {1'b0, bits_to_send} + 7'd3;
  assign load_units = four_bit ? 6'(len_plus3 >> 2) : bits_to_send;
  assign next_sr    = mode4 ? {shift_reg[59:0], 4'b0000} : {shift_reg[62:0], 1'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      sdio      <= 4'd0;
      shift_reg <= 64'd0;
      units     <= 6'd0;
      mode4     <= 1'b0;
      half_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            mode4     <= four_bit;
            shift_reg <= load_sr;
            units     <= load_units;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            sdio      <= unit_of(load_sr, four_bit);
            half_cnt  <= HALF_LOAD;
            state     <= LOW;
          end else if (state == HOLD) begin
            if (hold_cnt == '0) begin
              cs_n  <= 1'b1;
              state <= IDLE;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
        end
        LOW: begin
          if (half_cnt == '0) begin
            sclk     <= 1'b1;
            half_cnt <= HALF_LOAD;
            state    <= HIGH;
          end else begin
            half_cnt <= half_cnt - HALF_ONE;
          end
        end
        HIGH: begin
          if (half_cnt == '0) begin
            sclk <= 1'b0;
            if (units > 6'd1) begin
              units     <= units - 6'd1;
              shift_reg <= next_sr;
              sdio      <= unit_of(next_sr, mode4);
              half_cnt  <= HALF_LOAD;
              state     <= LOW;
            end else begin
              busy     <= 1'b0;
              sdio     <= 4'd0;
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end
          end else begin
            half_cnt <= half_cnt - HALF_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9958_spi_tx.sv
// Directed bench for ad9958_spi_tx: checks per-rise SDIO units, busy length,
// CS_N hold/release, ignored requests and asynchronous reset.
module tb_ad9958_spi_tx;

  logic        clock;
  logic        reset_n;
  logic        trigger;
  logic        four_bit;
  logic [5:0]  bits_to_send;
  logic [63:0] data_input;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic [3:0]  sdio;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [3:0] rise_q[$];
  logic [3:0] exp_q[$];
  logic       cs_watch = 1'b0;
  int         cs_breaks = 0;

  ad9958_spi_tx #(.CLK_DIV(2), .CS_HOLD(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .four_bit     (four_bit),
    .bits_to_send (bits_to_send),
    .data_input   (data_input),
    .busy         (busy),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .sdio         (sdio),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DDS side: sample sdio on each SCLK rise
  always @(posedge sclk) rise_q.push_back(sdio);

  always @(negedge clock) if (cs_watch && cs_n) cs_breaks++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic fb, input logic [5:0] nb, input logic [63:0] d);
    @(negedge clock);
    trigger      = 1'b1;
    four_bit     = fb;
    bits_to_send = nb;
    data_input   = d;
    @(negedge clock);
    trigger = 1'b0;
  endtask

  // counts negedges until busy drops; optionally pulses a stray trigger
  task automatic wait_busy(output int cycles, input int glitch_at);
    cycles = 0;
    while (busy && cycles < 1000) begin
      @(negedge clock);
      cycles++;
      if (cycles == glitch_at) begin
        trigger      = 1'b1;
        four_bit     = 1'b1;
        bits_to_send = 6'd5;
        data_input   = '1;
      end else begin
        trigger = 1'b0;
      end
    end
    trigger = 1'b0;
  endtask

  task automatic wait_cs_release(output int cycles);
    cycles = 0;
    while (!cs_n && cycles < 1000) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic push_bits(input logic [63:0] d, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back({3'b000, d[i]});
  endtask

  // scoreboard: compare SCLK-rise samples from index base against exp_q
  task automatic check_units(input string tag, input int base);
    check({tag, "_rises"}, 64'(rise_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < rise_q.size())
        check($sformatf("%s_unit%0d", tag, i), 64'(rise_q[base + i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    int base;
    reset_n      = 1'b0;
    trigger      = 1'b0;
    four_bit     = 1'b0;
    bits_to_send = 6'd0;
    data_input   = 64'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_sdio", 64'(sdio), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1-bit, 8 bits, 0x80
    base = rise_q.size();
    send(1'b0, 6'd8, 64'h80);
    check("t1_busy_rise", 64'(busy), 64'd1);
    check("t1_cs_low", 64'(cs_n), 64'd0);
    wait_busy(cyc, -1);
    check("t1_busy_len", 64'(cyc), 64'd32);
    check("t1_sdio_idle", 64'(sdio), 64'd0);
    wait_cs_release(cyc);
    check("t1_cs_hold", 64'(cyc), 64'd16);
    push_bits(64'h80, 8);
    check_units("t1", base);

    // 4-bit, 32 bits
    base = rise_q.size();
    send(1'b1, 6'd32, 64'h12345678);
    wait_busy(cyc, -1);
    check("t2_busy_len", 64'(cyc), 64'd32);
    for (int i = 1; i <= 8; i++) exp_q.push_back(4'(i));
    check_units("t2", base);
    wait_cs_release(cyc);

    // back-to-back frame, 1-bit mode both parts
    base = rise_q.size();
    send(1'b0, 6'd8, 64'h04);
    cs_watch = 1'b1;
    wait_busy(cyc, -1);
    repeat (2) @(negedge clock);
    send(1'b0, 6'd32, 64'hDEADBEEF);
    wait_busy(cyc, -1);
    check("t3_busy_len", 64'(cyc), 64'd128);
    cs_watch = 1'b0;
    check("t3_cs_breaks", 64'(cs_breaks), 64'd0);
    check("t3_total_rises", 64'(rise_q.size() - base), 64'd40);
    push_bits(64'h04, 8);
    push_bits(64'hDEADBEEF, 32);
    check_units("t3", base);
    wait_cs_release(cyc);
    check("t3_cs_hold", 64'(cyc), 64'd16);

    // zero-length request is ignored
    base = rise_q.size();
    send(1'b1, 6'd0, 64'hFFFF);
    repeat (3) @(negedge clock);
    check("t4_zero_busy", 64'(busy), 64'd0);
    check("t4_zero_cs", 64'(cs_n), 64'd1);
    check("t4_zero_state", 64'(fsm_state), 64'd0);
    check("t4_zero_rises", 64'(rise_q.size() - base), 64'd0);

    // trigger mid-transfer is ignored
    base = rise_q.size();
    send(1'b0, 6'd8, 64'hA5);
    wait_busy(cyc, 10);
    check("t4_glitch_busy_len", 64'(cyc), 64'd32);
    push_bits(64'hA5, 8);
    check_units("t4_glitch", base);

    // padded 4-bit: 10 bits of 0x3FF -> F,F,C
    base = rise_q.size();
    send(1'b1, 6'd10, 64'h3FF);
    wait_busy(cyc, -1);
    check("t4_pad_busy_len", 64'(cyc), 64'd12);
    exp_q.push_back(4'hF);
    exp_q.push_back(4'hF);
    exp_q.push_back(4'hC);
    check_units("t4_pad", base);
    wait_cs_release(cyc);

    // asynchronous reset mid-transfer
    base = rise_q.size();
    send(1'b0, 6'd8, 64'hFF);
    cyc = 0;
    while (rise_q.size() - base < 5 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("t5_rises_before_rst", 64'(rise_q.size() - base), 64'd5);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_cs_n", 64'(cs_n), 64'd1);
    check("t5_rst_sclk", 64'(sclk), 64'd0);
    check("t5_rst_sdio", 64'(sdio), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_state", 64'(fsm_state), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    base = rise_q.size();
    send(1'b0, 6'd8, 64'h5A);
    wait_busy(cyc, -1);
    check("t5_after_busy_len", 64'(cyc), 64'd32);
    push_bits(64'h5A, 8);
    check_units("t5_after", base);
    wait_cs_release(cyc);
    check("t5_after_cs_hold", 64'(cyc), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9958_spi_tx.md
# ad9958_spi_tx

Serial-port transmitter for the AD9958 DDS. It accepts one transfer request at a time from the controller core through the `trigger`/`busy` handshake, then shifts `bits_to_send` bits of `data_input` MSB-first onto SCLK/SDIO. Both the 1-bit and 4-bit AD9958 serial modes are supported. Between back-to-back requests it holds CS_N low, so an instruction byte and its register payload land in a single chip-select frame.

## Interface
- `CLK_DIV`, default 2: `clock` cycles per SCLK half-period. Must be ≥1.
- `CS_HOLD`, default 16: idle `clock` cycles after a transfer before CS_N is released. Must be ≥1.
- `clock` in 1: the single clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `trigger` in 1: request strobe. Sampled only in IDLE or HOLD.
- `four_bit` in 1: 1 selects 4-bit serial mode; 0 selects 1-bit mode on SDIO_0.
- `bits_to_send` in 6: payload length in bits, 0–63.
- `data_input` in 64: payload, right-aligned. Bit `bits_to_send-1` is sent first.
- `busy` out 1: high while a transfer is in progress.
- `sclk` out 1: serial clock to the DDS, idle low.
- `cs_n` out 1: chip select to the DDS, active low.
- `sdio` out 4: serial data. In 1-bit mode only `sdio[0]` is used; `sdio[3:1]` are 0.

## Operation
- Reset values: `busy`=0, `sclk`=0, `cs_n`=1, `sdio`=0, state IDLE, all counters 0.
- States:
  - IDLE: `cs_n`=1.
  - LOW: `sclk`=0, data valid on `sdio`.
  - HIGH: `sclk`=1.
  - HOLD: `cs_n`=0, no transfer running.
- Request acceptance (IDLE or HOLD, `trigger`=1, `bits_to_send`≠0), all on the same edge:
  - Capture `four_bit`.
  - Load the shift register with `data_input << (64 - bits_to_send)` (MSB-aligned).
  - Set the unit count: `bits_to_send` in 1-bit mode, `ceil(bits_to_send/4)` in 4-bit mode.
  - Set `busy`=1 and `cs_n`=0.
  - Drive the first unit on `sdio`, load the half-period counter with `CLK_DIV-1`, enter LOW.
- `trigger` with `bits_to_send`=0 is ignored: no `busy`, no state change.
- Unit mapping:
  - 1-bit mode: `sdio[0]` = shift-register bit 63.
  - 4-bit mode: `sdio[3:0]` = shift-register bits [63:60]; `sdio[3]` carries the earliest bit.
  - Padding past the last payload bit (4-bit mode, length not a multiple of 4) is 0.
- LOW: when the counter reaches 0, set `sclk`=1, reload the counter, enter HIGH.
- HIGH: when the counter reaches 0, set `sclk`=0, then:
  - If more than one unit remains: decrement the unit count, shift left by 1 (1-bit mode) or 4 (4-bit mode), drive the next unit, reload the counter, enter LOW.
  - If this was the last unit: `busy`=0, `sdio`=0, load the hold counter with `CS_HOLD-1`, enter HOLD.
- HOLD: `trigger` follows the acceptance rules without toggling `cs_n`. When the hold counter reaches 0 with no request, set `cs_n`=1 and enter IDLE.
- `trigger` while `busy`=1 is ignored; it is neither queued nor allowed to corrupt the transfer.
- Asserting `reset_n` mid-transfer immediately forces every output to its reset value, which aborts the DDS frame.

## Timing
- Busy rise: `busy` rises on the edge that samples `trigger`=1. A controller that pulses `trigger` for one cycle and waits for `~(busy|trigger)` therefore never sees a false idle.
- Transfer length: N units take exactly N·2·`CLK_DIV` cycles from the accepting edge to the edge where `busy` falls.
  - Example: 8 bits, 1-bit mode, `CLK_DIV`=2 gives 32 cycles.
  - Example: 32 bits, 4-bit mode gives 8 units, 32 cycles.
- `sdio` changes only on the edges where `sclk` falls, or on acceptance. It is therefore stable for `CLK_DIV` cycles before and after each rising `sclk` (DDS samples on the rise).
- Chip-select setup:
  - First unit after IDLE: `cs_n` falls together with the first `sdio` value, giving `CLK_DIV` cycles of setup before the first `sclk` rise.
  - Release: `cs_n` rises exactly `CS_HOLD` cycles after `busy` falls, unless a new request is accepted first.
- Back-to-back requests: a request accepted in HOLD on cycle k (k < `CS_HOLD`) keeps `cs_n` low continuously across both transfers.

## Test plan
- **1-bit, 8 bits.** After reset, pulse `trigger` with `four_bit`=0, `bits_to_send`=8, `data_input`=0x80. Expect:
  - `busy` high for 32 cycles.
  - 8 `sclk` rises; `sdio[0]` = 1,0,0,0,0,0,0,0 at the rises.
  - `cs_n` rises 16 cycles after `busy` falls.
- **4-bit, 32 bits.** `four_bit`=1, `bits_to_send`=32, `data_input`=0x12345678. Expect 8 rises with `sdio` = 1,2,3,4,5,6,7,8, and `busy` high for 32 cycles.
- **Back-to-back frame.** Send the 8-bit instruction 0x04, then 3 cycles after `busy` falls send 32-bit 0xDEADBEEF. Expect `cs_n` low throughout and 40 total `sclk` rises.
- **Ignored and padded requests.**
  - `trigger` with `bits_to_send`=0: `busy` stays 0, outputs unchanged.
  - `trigger` pulsed mid-transfer: the waveform is identical to the undisturbed case.
  - 4-bit mode, `bits_to_send`=10, data 0x3FF: 3 units F,F,C.
- **Reset mid-transfer.** Drop `reset_n` after 5 `sclk` rises. Expect `cs_n`=1, `sclk`=0, `sdio`=0, `busy`=0 asynchronously. After release, a new 8-bit transfer completes normally.
